// File: rtl/ieeedrv_track_io.sv
// Track-buffer SD transfer controller: writes back the dirty buffered track and loads
// the selected track as 512-byte block transfers. Optional write protect: IEEEDRV_WRPROT_EN.
module ieeedrv_track_io #(
    parameter int unsigned TRACK_BLKS = 16,
    parameter int unsigned BLK_W      = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             img_mounted,
    input  logic [31:0]      img_size,
    input  logic [6:0]       track,
    input  logic             save_track,
    input  logic             sd_ack,
`ifdef IEEEDRV_WRPROT_EN
    input  logic             img_readonly,
`endif
    output logic [31:0]      sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    output logic [BLK_W-1:0] buff_blk,
    output logic             loaded,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        WR_REQ = 3'd2,
        ACK_HI = 3'd3,
        ACK_LO = 3'd4
    } state_t;

    state_t           state_r, state_d_s;
    logic [6:0]       cur_track_r, cur_track_d_s;
    logic [BLK_W-1:0] blk_r, blk_d_s, buff_blk_r, buff_blk_d_s;
    logic [31:0]      sd_lba_r, sd_lba_d_s;
    logic             sd_rd_r, sd_rd_d_s, sd_wr_r, sd_wr_d_s;
    logic             save_q_r, save_pend_r, save_pend_d_s, load_pend_r, load_pend_d_s;
    logic             valid_r, valid_d_s, abort_r, abort_d_s, is_wr_r, is_wr_d_s;
    logic             loaded_r, loaded_d_s, busy_r, busy_d_s;
    logic             save_take_s, load_take_s, load_set_s, wr_prot_s;
    logic             track_ok_s, cur_ok_s;
    logic             unused_s;

    function automatic logic in_range(input logic [6:0] t, input logic [31:0] sz);
        logic [31:0] need;
        need     = ({25'd0, t} + 32'd1) * TRACK_BLKS;
        in_range = (need <= {9'd0, sz[31:9]});
    endfunction

    assign unused_s   = ^img_size[8:0];
    assign track_ok_s = in_range(track, img_size);
    assign cur_ok_s   = in_range(cur_track_r, img_size);
`ifdef IEEEDRV_WRPROT_EN
    assign wr_prot_s  = img_readonly;
`else
    assign wr_prot_s  = 1'b0;
`endif

    // Next-state, request capture and registered-output computation
    always_comb begin
        state_d_s     = state_r;
        cur_track_d_s = cur_track_r;
        blk_d_s       = blk_r;
        buff_blk_d_s  = buff_blk_r;
        sd_lba_d_s    = sd_lba_r;
        sd_rd_d_s     = sd_rd_r;
        sd_wr_d_s     = sd_wr_r;
        valid_d_s     = valid_r;
        abort_d_s     = abort_r;
        is_wr_d_s     = is_wr_r;
        save_take_s   = 1'b0;
        load_take_s   = 1'b0;

        case (state_r)
            IDLE: begin
                abort_d_s = 1'b0;
                if (save_pend_r && valid_r && cur_ok_s && !wr_prot_s) begin
                    save_take_s = 1'b1;
                    blk_d_s     = {BLK_W{1'b0}};
                    is_wr_d_s   = 1'b1;
                    state_d_s   = WR_REQ;
                end else if (save_pend_r) begin
                    save_take_s = 1'b1;
                end else if (load_pend_r) begin
                    load_take_s   = 1'b1;
                    cur_track_d_s = track;
                    valid_d_s     = 1'b0;
                    if (track_ok_s) begin
                        blk_d_s   = {BLK_W{1'b0}};
                        is_wr_d_s = 1'b0;
                        state_d_s = RD_REQ;
                    end else begin
                        state_d_s = IDLE;
                    end
                end else begin
                    state_d_s = IDLE;
                end
            end
            RD_REQ: begin
                sd_lba_d_s   = {25'd0, cur_track_r} * TRACK_BLKS + {{(32-BLK_W){1'b0}}, blk_r};
                buff_blk_d_s = blk_r;
                sd_rd_d_s    = 1'b1;
                state_d_s    = ACK_HI;
            end
            WR_REQ: begin
                sd_lba_d_s   = {25'd0, cur_track_r} * TRACK_BLKS + {{(32-BLK_W){1'b0}}, blk_r};
                buff_blk_d_s = blk_r;
                if (wr_prot_s) begin
                    state_d_s = IDLE;
                end else begin
                    sd_wr_d_s = 1'b1;
                    state_d_s = ACK_HI;
                end
            end
            ACK_HI: begin
                if (sd_ack) begin
                    sd_rd_d_s = 1'b0;
                    sd_wr_d_s = 1'b0;
                    state_d_s = ACK_LO;
                end else begin
                    state_d_s = ACK_HI;
                end
            end
            ACK_LO: begin
                if (sd_ack) begin
                    state_d_s = ACK_LO;
                end else if (abort_r || img_mounted) begin
                    state_d_s = IDLE;
                end else if (blk_r == BLK_W'(TRACK_BLKS - 1)) begin
                    state_d_s = IDLE;
                    if (!is_wr_r) begin
                        valid_d_s = 1'b1;
                    end else begin
                        valid_d_s = valid_r;
                    end
                end else begin
                    blk_d_s   = blk_r + BLK_W'(1);
                    state_d_s = is_wr_r ? WR_REQ : RD_REQ;
                end
            end
            default: begin
                sd_rd_d_s = 1'b0;
                sd_wr_d_s = 1'b0;
                state_d_s = IDLE;
            end
        endcase

        // A consumed load must not be re-armed by the track it just latched
        load_set_s    = (track != cur_track_r) || (!valid_r && (state_r == IDLE) && track_ok_s);
        save_pend_d_s = (save_pend_r && !save_take_s) || (save_track != save_q_r);
        load_pend_d_s = load_take_s ? 1'b0 : (load_pend_r || load_set_s);

        if (img_mounted) begin
            save_pend_d_s = 1'b0;
            load_pend_d_s = 1'b1;
            valid_d_s     = 1'b0;
            abort_d_s     = (state_d_s != IDLE);
        end else begin
            abort_d_s     = abort_d_s;
        end

        // A completed read with a newer track pending is not reported as loaded
        loaded_d_s = valid_d_s && !load_pend_d_s;
        busy_d_s   = (state_d_s != IDLE) || save_pend_d_s || load_pend_d_s;
    end

    // State and output registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cur_track_r <= 7'd0;
            blk_r       <= {BLK_W{1'b0}};
            buff_blk_r  <= {BLK_W{1'b0}};
            sd_lba_r    <= 32'd0;
            sd_rd_r     <= 1'b0;
            sd_wr_r     <= 1'b0;
            save_q_r    <= save_track;
            save_pend_r <= 1'b0;
            load_pend_r <= 1'b0;
            valid_r     <= 1'b0;
            abort_r     <= 1'b0;
            is_wr_r     <= 1'b0;
            loaded_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_d_s;
            cur_track_r <= cur_track_d_s;
            blk_r       <= blk_d_s;
            buff_blk_r  <= buff_blk_d_s;
            sd_lba_r    <= sd_lba_d_s;
            sd_rd_r     <= sd_rd_d_s;
            sd_wr_r     <= sd_wr_d_s;
            save_q_r    <= save_track;
            save_pend_r <= save_pend_d_s;
            load_pend_r <= load_pend_d_s;
            valid_r     <= valid_d_s;
            abort_r     <= abort_d_s;
            is_wr_r     <= is_wr_d_s;
            loaded_r    <= loaded_d_s;
            busy_r      <= busy_d_s;
        end
    end

    assign sd_lba   = sd_lba_r;
    assign sd_rd    = sd_rd_r;
    assign sd_wr    = sd_wr_r;
    assign buff_blk = buff_blk_r;
    assign loaded   = loaded_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_ieeedrv_track_io.sv
// Scoreboarded bench for ieeedrv_track_io: expected SD block requests are queued with the
// stimulus and checked by an SD responder model as the DUT issues them.
module tb_ieeedrv_track_io;

    localparam int TRACK_BLKS = 16;
    localparam int BLK_W      = 4;

    logic             clk_sys = 1'b0;
    logic             reset = 1'b1;
    logic             img_mounted = 1'b0;
    logic [31:0]      img_size = 32'd0;
    logic [6:0]       track = 7'd0;
    logic             save_track = 1'b0;
    logic             sd_ack = 1'b0;
`ifdef IEEEDRV_WRPROT_EN
    logic             img_readonly = 1'b0;
`endif
    logic [31:0]      sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic [BLK_W-1:0] buff_blk;
    logic             loaded;
    logic             busy;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic        resp_en = 1'b0;
    logic [36:0] exp_q[$];

    ieeedrv_track_io #(.TRACK_BLKS(TRACK_BLKS), .BLK_W(BLK_W)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .track       (track),
        .save_track  (save_track),
        .sd_ack      (sd_ack),
`ifdef IEEEDRV_WRPROT_EN
        .img_readonly(img_readonly),
`endif
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .buff_blk    (buff_blk),
        .loaded      (loaded),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // SD layer model: pops the expected request, acks after a random delay
    initial begin : responder
        logic [36:0] e;
        int          n;
        forever begin
            @(negedge clk_sys);
            if (resp_en && (sd_rd || sd_wr)) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_req: got rd=%0b wr=%0b lba=%0d, expected no request", sd_rd, sd_wr, sd_lba);
                end else begin
                    e = exp_q.pop_front();
                    if ({sd_wr, sd_rd, buff_blk, sd_lba} !== {e[36], ~e[36], e[35:32], e[31:0]}) begin
                        tests_failed++;
                        $display("FAIL sd_req: got wr=%0b rd=%0b blk=%0d lba=%0d, expected wr=%0b blk=%0d lba=%0d",
                                 sd_wr, sd_rd, buff_blk, sd_lba, e[36], e[35:32], e[31:0]);
                    end
                end
                repeat ($urandom_range(0, 2)) @(negedge clk_sys);
                sd_ack = 1'b1;
                n = 0;
                while ((sd_rd || sd_wr) && n < 20) begin
                    @(negedge clk_sys);
                    n++;
                end
                tests_run++;
                if (n >= 20) begin
                    tests_failed++;
                    $display("FAIL req_drop: request still high after %0d cycles of ack, expected drop", n);
                end
                sd_ack = 1'b0;
            end
        end
    end

    task automatic push_track(input logic wr, input int trk);
        for (int b = 0; b < TRACK_BLKS; b++) begin
            exp_q.push_back({wr, 4'(b), 32'(trk * TRACK_BLKS + b)});
        end
    endtask

    task automatic mount(input logic [31:0] size, input logic [6:0] trk);
        @(negedge clk_sys);
        img_size    = size;
        track       = trk;
        img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
    endtask

    task automatic wait_idle(output int loaded_busy);
        int n;
        n = 0;
        loaded_busy = 0;
        @(negedge clk_sys);
        while (busy && n < 3000) begin
            if (loaded) loaded_busy++;
            @(negedge clk_sys);
            n++;
        end
        tests_run++;
        if (busy) begin
            tests_failed++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, expected 0", busy, n);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain: %0d requests outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        tests_run++;
        if ({sd_rd, sd_wr, sd_lba, buff_blk, loaded, busy} !== 38'd0) begin
            tests_failed++;
            $display("FAIL reset_vals: got rd=%0b wr=%0b lba=%0h blk=%0h loaded=%0b busy=%0b, expected all 0",
                     sd_rd, sd_wr, sd_lba, buff_blk, loaded, busy);
        end
        reset = 1'b0;
        resp_en = 1'b1;
        repeat (5) @(negedge clk_sys);
        tests_run++;
        if (busy !== 1'b0 || loaded !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got busy=%0b loaded=%0b, expected 0 0", busy, loaded);
        end
    endtask

    task automatic test_mount_load();
        int lb;
        push_track(1'b0, 38);
        mount(32'h0010_0000, 7'd38);
        wait_idle(lb);
        tests_run++;
        if (loaded !== 1'b1) begin
            tests_failed++;
            $display("FAIL mount_loaded: got %0b, expected 1", loaded);
        end
    endtask

    task automatic test_save_on_step();
        int lb;
        push_track(1'b1, 38);
        push_track(1'b0, 39);
        @(negedge clk_sys);
        save_track = ~save_track;
        track      = 7'd39;
        wait_idle(lb);
        tests_run++;
        if (loaded !== 1'b1) begin
            tests_failed++;
            $display("FAIL save_step_loaded: got %0b, expected 1", loaded);
        end
    endtask

    task automatic test_mid_read_change();
        int lb;
        int n;
        push_track(1'b0, 10);
        push_track(1'b0, 11);
        @(negedge clk_sys);
        track = 7'd10;
        n = 0;
        while (!(sd_rd && buff_blk == 4'd5) && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        tests_run++;
        if (n >= 500) begin
            tests_failed++;
            $display("FAIL blk5_wait: block 5 read not seen in %0d cycles, expected it", n);
        end
        track = 7'd11;
        wait_idle(lb);
        tests_run++;
        if (lb != 0 || loaded !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_read_loaded: got %0d early loaded cycles, final loaded=%0b, expected 0 and 1", lb, loaded);
        end
    endtask

    task automatic test_out_of_range();
        int reqs;
        mount(32'h0000_2000, 7'd1);
        @(negedge clk_sys);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_busy: got %0b two cycles after mount, expected 0", busy);
        end
        reqs = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr) reqs++;
        end
        tests_run++;
        if (reqs != 0 || loaded !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_idle: got %0d request cycles loaded=%0b, expected 0 and 0", reqs, loaded);
        end
    endtask

    task automatic test_reset_mid_write();
        int lb;
        int n;
        int reqs;
        push_track(1'b0, 0);
        mount(32'h0000_2000, 7'd0);
        wait_idle(lb);
        tests_run++;
        if (loaded !== 1'b1) begin
            tests_failed++;
            $display("FAIL trk0_loaded: got %0b, expected 1", loaded);
        end
        resp_en = 1'b0;
        @(negedge clk_sys);
        save_track = ~save_track;
        track      = 7'd1;
        n = 0;
        while (!sd_wr && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        tests_run++;
        if (sd_wr !== 1'b1 || sd_lba !== 32'd0) begin
            tests_failed++;
            $display("FAIL wr_before_reset: got wr=%0b lba=%0d, expected 1 and 0", sd_wr, sd_lba);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (sd_wr !== 1'b0 || sd_rd !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got wr=%0b rd=%0b busy=%0b loaded=%0b, expected all 0", sd_wr, sd_rd, busy, loaded);
        end
        @(negedge clk_sys);
        reset   = 1'b0;
        resp_en = 1'b1;
        reqs = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr) reqs++;
        end
        tests_run++;
        if (reqs != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: got %0d request cycles busy=%0b, expected 0 and 0", reqs, busy);
        end
    endtask

`ifdef IEEEDRV_WRPROT_EN
    task automatic test_wrprot();
        int lb;
        push_track(1'b0, 0);
        mount(32'h0000_2000, 7'd0);
        wait_idle(lb);
        img_readonly = 1'b1;
        @(negedge clk_sys);
        save_track = ~save_track;
        wait_idle(lb);
        tests_run++;
        if (busy !== 1'b0 || loaded !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrprot: got busy=%0b loaded=%0b, expected 0 and 1", busy, loaded);
        end
        img_readonly = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_mount_load();
        test_save_on_step();
        test_mid_read_change();
        test_out_of_range();
        test_reset_mid_write();
`ifdef IEEEDRV_WRPROT_EN
        test_wrprot();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
